// File: rtl/sync_ram_clr.sv
// rtl/sync_ram_clr.sv - single-port synchronous RAM with registered read and clear sweep
// Optional write-first bypass on same-cycle write+read: SYNC_RAM_CLR_WRITE_FIRST_EN.
module sync_ram_clr #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_rd_valid,
  output logic              o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_CLEAR = 1'b1;

  logic              r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;

  logic              w_idle;
  logic              w_wr;
  logic              w_rd;
  logic              w_sweep;
  logic              w_last;
  logic [DATA_W-1:0] w_rd_data;

  // clr overrides everything, so accesses are only honoured in IDLE with no clr.
  assign w_idle  = (r_state == S_IDLE);
  assign w_wr    = w_idle & ~i_clr & i_we;
  assign w_rd    = w_idle & ~i_clr & i_re;
  assign w_sweep = (r_state == S_CLEAR) & ~i_clr;
  assign w_last  = (r_ptr == {ADDR_W{1'b1}});

`ifdef SYNC_RAM_CLR_WRITE_FIRST_EN
  assign w_rd_data = w_wr ? i_data_in : r_mem[i_addr];
`else
  assign w_rd_data = r_mem[i_addr];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_CLEAR;
      r_ptr      <= '0;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else if (i_clr) begin
      r_state    <= S_CLEAR;
      r_ptr      <= '0;
      r_rd_valid <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_ptr      <= r_ptr + ADDR_W'(1);
      r_rd_valid <= 1'b0;
      if (w_last) begin
        r_state <= S_IDLE;
      end
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_data_out <= w_rd_data;
      end
    end
  end

  // The array has no reset; the sweep that follows reset zeroes it.
  always_ff @(posedge i_clk) begin
    if (w_sweep) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr) begin
      r_mem[i_addr] <= i_data_in;
    end
  end

  assign o_data_out = r_data_out;
  assign o_rd_valid = r_rd_valid;
  assign o_busy     = (r_state == S_CLEAR);

endmodule

// File: tb/tb_sync_ram_clr.sv
// tb/tb_sync_ram_clr.sv - scoreboard bench for sync_ram_clr (DEPTH=4, DATA_W=4)
module tb_sync_ram_clr;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic              re;
  logic              clr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rdv;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] mon_exp;

  always #5 clk = ~clk;

  sync_ram_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_we       (we),
    .i_re       (re),
    .i_addr     (addr),
    .i_data_in  (din),
    .i_clr      (clr),
    .o_data_out (dout),
    .o_rd_valid (rdv),
    .o_busy     (busy)
  );

  // Read-data scoreboard: every rd_valid pulse must match the oldest queued read.
  always @(negedge clk) begin
    if (rdv === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: rd_valid=1 data_out=%0d, required no read pending", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dout !== mon_exp) begin
          n_err++;
          $display("FAIL rd_data: data_out=%0d, required %0d", dout, mon_exp);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0; addr = '0; din = '0;
    #2;
    n_cmp++;
    if (busy !== 1'b1 || dout !== 4'd0 || rdv !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: busy=%0b data_out=%0d rd_valid=%0b, required 1/0/0", busy, dout, rdv);
    end
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick;
      n_cmp++;
      if (busy !== (k < DEPTH)) begin
        n_err++;
        $display("FAIL reset_sweep_busy: edge %0d busy=%0b, required %0b", k, busy, (k < DEPTH));
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      re = 1'b1; addr = ADDR_W'(a);
      exp_q.push_back(ref_mem[a]);
      tick;
      n_cmp++;
      if (rdv !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read_valid: addr %0d rd_valid=%0b, required 1", a, rdv);
      end
    end
    re = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    we = 1'b1; addr = 2'd0; din = 4'd15; ref_mem[0] = 4'd15;
    tick;
    we = 1'b0; re = 1'b1;
    exp_q.push_back(ref_mem[0]);
    tick;
    re = 1'b0;
    n_cmp++;
    if (rdv !== 1'b1) begin
      n_err++;
      $display("FAIL basic_valid: rd_valid=%0b, required 1", rdv);
    end
    tick;
    n_cmp++;
    if (rdv !== 1'b0 || dout !== 4'd15) begin
      n_err++;
      $display("FAIL basic_hold: rd_valid=%0b data_out=%0d, required 0/15", rdv, dout);
    end
  endtask

  task automatic test_full_range;
    logic [DATA_W-1:0] vals [DEPTH];
    vals[0] = 4'd3; vals[1] = 4'd7; vals[2] = 4'd9; vals[3] = 4'd12;
    for (int a = 0; a < DEPTH; a++) begin
      we = 1'b1; addr = ADDR_W'(a); din = vals[a]; ref_mem[a] = vals[a];
      tick;
    end
    we = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      re = 1'b1; addr = ADDR_W'(a);
      exp_q.push_back(ref_mem[a]);
      tick;
      n_cmp++;
      if (rdv !== 1'b1) begin
        n_err++;
        $display("FAIL full_b2b_valid: read %0d rd_valid=%0b, required 1", a, rdv);
      end
    end
    re = 1'b0;
    tick;
  endtask

  task automatic test_clear;
    clr = 1'b1; we = 1'b1; addr = 2'd1; din = 4'd5;
    tick;
    clr = 1'b0; we = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL clear_busy_start: busy=%0b, required 1", busy);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      tick;
      n_cmp++;
      if (busy !== (k < DEPTH)) begin
        n_err++;
        $display("FAIL clear_sweep_busy: edge %0d busy=%0b, required %0b", k, busy, (k < DEPTH));
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      re = 1'b1; addr = ADDR_W'(a);
      exp_q.push_back(ref_mem[a]);
      tick;
    end
    re = 1'b0;
    tick;
  endtask

  task automatic test_collision;
    we = 1'b1; addr = 2'd2; din = 4'd6; ref_mem[2] = 4'd6;
    tick;
    we = 1'b1; re = 1'b1; addr = 2'd2; din = 4'd10;
`ifdef SYNC_RAM_CLR_WRITE_FIRST_EN
    exp_q.push_back(4'd10);
`else
    exp_q.push_back(ref_mem[2]);
`endif
    ref_mem[2] = 4'd10;
    tick;
    we = 1'b0;
    exp_q.push_back(ref_mem[2]);
    tick;
    re = 1'b0;
    tick;
  endtask

  task automatic test_mid_sweep;
    clr = 1'b1;
    tick;
    clr = 1'b0; re = 1'b1; we = 1'b1; addr = 2'd3; din = 4'd9;
    tick;
    re = 1'b0; we = 1'b0;
    n_cmp++;
    if (rdv !== 1'b0 || busy !== 1'b1 || dout !== 4'd10) begin
      n_err++;
      $display("FAIL sweep_ignore: rd_valid=%0b busy=%0b data_out=%0d, required 0/1/10", rdv, busy, dout);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dout !== 4'd0 || busy !== 1'b1 || rdv !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: data_out=%0d busy=%0b rd_valid=%0b, required 0/1/0", dout, busy, rdv);
    end
    tick;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick;
      n_cmp++;
      if (busy !== (k < DEPTH)) begin
        n_err++;
        $display("FAIL mid_reset_sweep: edge %0d busy=%0b, required %0b", k, busy, (k < DEPTH));
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      re = 1'b1; addr = ADDR_W'(a);
      exp_q.push_back(ref_mem[a]);
      tick;
    end
    re = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full_range;
    test_clear;
    test_collision;
    test_mid_sweep;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL reads_outstanding: %0d reads never returned, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_ram_clr.md
# sync_ram_clr

Parametrised single-port synchronous RAM with registered read, read-valid strobe and a built-in clear sequencer. This is the next generation of the small fixed 4x4 read/write-enable RAM. After reset, or on request, it sweeps every word to zero while reporting busy, then serves reads and writes. It is the generic storage block for slot-stock, price and coin-count tables in the vending datapath.

## Interface
- DATA_W, 4, word width in bits (≥1)
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W words
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable
- re  in  1  read enable
- addr  in  ADDR_W  word address for read and write
- data_in  in  DATA_W  write data
- clr  in  1  synchronous request to zero the whole array
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe: data_out updated by a read
- busy  out  1  clear sweep in progress; we/re ignored

## Operation
- States: CLEAR and IDLE; an ADDR_W-bit sweep pointer is used.
- CLEAR, on each edge: mem[ptr] <= 0 and ptr increments. On the edge with ptr == DEPTH-1, the block moves to IDLE and ptr wraps to 0. The sweep lasts exactly DEPTH cycles.
- CLEAR: busy = 1. we and re are ignored, so no write occurs and rd_valid stays 0. data_out holds its value.
- IDLE: busy = 0.
  - we=1: mem[addr] <= data_in at the edge.
  - re=1: data_out <= mem[addr] at the edge, and rd_valid = 1 for the following cycle.
  - re=0: rd_valid = 0 and data_out holds its value.
- we and re in the same cycle at different addresses: both are performed.
- we and re at the same address: the result depends on the configuration macro (see Configuration).
- clr=1, sampled at an edge in either state: go to CLEAR and set ptr to 0. The sweep restarts even mid-sweep. Any we/re in that cycle is ignored.
- clr has priority over we/re.
- Reset (async, any time, including mid-sweep):
  - state = CLEAR, ptr = 0
  - data_out = 0, rd_valid = 0, busy = 1
  - The array is not reset directly; the sweep that follows reset zeroes it.
- No arithmetic besides the pointer increment, which wraps modulo DEPTH.

## Timing
- busy is high for DEPTH cycles after rst deasserts, or after the edge that samples clr. For DEPTH=4, the first usable edge is the 5th edge after reset release.
- Write latency: stored at the sampling edge. A read issued on the next edge returns the new value.
- Read latency: 1 cycle. data_out and rd_valid change together after the edge that sampled re.
- rd_valid never stays high two cycles unless re is held. Back-to-back reads give a data_out and rd_valid each cycle.
- busy, rd_valid and data_out are all registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: SYNC_RAM_CLR_WRITE_FIRST_EN.
- Defined: on same-cycle we & re to the same address, data_out <= data_in (write-first bypass).
- Undefined: data_out <= the old mem[addr] (read-first). The write still completes in both cases.

## Test plan
- Reset sweep: assert rst, release it, and count edges → busy = 1 for exactly 4 cycles (DEPTH=4), then 0. Then read addr 0..3 → each returns 0 with rd_valid pulsing.
- Basic write/read: in IDLE, write 15 to addr 0, then re on the next cycle → data_out = 15 and rd_valid = 1 for one cycle. rd_valid = 0 afterwards with re=0, and data_out holds 15.
- Full-range: write 3, 7, 9, 12 to addr 0..3, then four back-to-back reads → data_out sequence 3, 7, 9, 12 with rd_valid high all 4 cycles.
- Clear request: after the full-range writes, pulse clr together with we=1 to addr 1 (data 5) → busy high 4 cycles and the write is dropped. Afterwards all addresses read 0.
- Same-address collision: mem[2] = 6, then we=1, re=1, addr=2, data_in=10 → data_out = 10 with SYNC_RAM_CLR_WRITE_FIRST_EN, 6 without. A subsequent read returns 10 in both builds.
- Mid-sweep reset/ignored access: during CLEAR, issue re=1 → rd_valid stays 0. Assert rst at sweep cycle 2 → data_out = 0, busy stays 1, and the full 4-cycle sweep restarts from ptr 0.
